// File: rtl/wb_stream_arb2.sv
// Two-master round-robin Wishbone arbiter; a grant is held for the whole cyc window so bursts pass unbroken.
// Define WB_ARB_TIMEOUT_EN to abort cycles whose slave stalls for TIMEOUT_CYCLES cycles.
module wb_stream_arb2 #(
  parameter int WB_AW          = 32,
  parameter int WB_DW          = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,

  input  logic [WB_AW-1:0]     m0_adr_i,
  input  logic [WB_DW-1:0]     m0_dat_i,
  input  logic [WB_DW/8-1:0]   m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic [2:0]           m0_cti_i,
  input  logic [1:0]           m0_bte_i,
  output logic [WB_DW-1:0]     m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  output logic                 m0_rty_o,

  input  logic [WB_AW-1:0]     m1_adr_i,
  input  logic [WB_DW-1:0]     m1_dat_i,
  input  logic [WB_DW/8-1:0]   m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic [2:0]           m1_cti_i,
  input  logic [1:0]           m1_bte_i,
  output logic [WB_DW-1:0]     m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 m1_rty_o,

  output logic [WB_AW-1:0]     s_adr_o,
  output logic [WB_DW-1:0]     s_dat_o,
  output logic [WB_DW/8-1:0]   s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic [2:0]           s_cti_o,
  output logic [1:0]           s_bte_o,
  input  logic [WB_DW-1:0]     s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [1:0] ABORT = 2'd3;
`endif

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       last_nxt;
  logic       gnt0;
  logic       gnt1;
  logic       granted;
  logic       resp;
  logic       timeout_hit;

  assign gnt0    = (state == GNT0);
  assign gnt1    = (state == GNT1);
  assign granted = gnt0 | gnt1;
  assign resp    = s_ack_i | s_err_i | s_rty_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] stall_cnt;
  logic             stalled;

  // A strobed beat with no response of any kind is a stalled cycle.
  assign stalled     = granted & s_stb_o & ~resp;
  assign timeout_hit = stalled & (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stall_cnt <= '0;
    end else if (!granted || resp || timeout_hit) begin
      stall_cnt <= '0;
    end else if (stalled) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Grants only start from IDLE, which guarantees one dead bus cycle between owners.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last)) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_nxt = ABORT;
`endif
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_nxt = ABORT;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (last ? !m1_cyc_i : !m0_cyc_i) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Request and response muxes are purely combinational on the registered state.
  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = 3'd0;
    s_bte_o  = 2'd0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (gnt0) begin
      s_we_o   = m0_we_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
      m0_ack_o = s_ack_i;
      m0_err_o = s_err_i | timeout_hit;
      m0_rty_o = s_rty_i;
    end else if (gnt1) begin
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_we_o   = m1_we_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_cti_o  = m1_cti_i;
      s_bte_o  = m1_bte_i;
      m1_ack_o = s_ack_i;
      m1_err_o = s_err_i | timeout_hit;
      m1_rty_o = s_rty_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_stream_arb2.sv
// Directed bench for wb_stream_arb2: cycle table plus hand sequences for reset, alternation, no-preemption and timeout.
module tb_wb_stream_arb2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [AW-1:0] ADR0 = 32'h0000_0100;
  localparam logic [AW-1:0] ADR1 = 32'h0000_0200;
  localparam logic [DW-1:0] DAT0 = 32'hA5A5_A5A5;
  localparam logic [DW-1:0] DAT1 = 32'h5A5A_5A5A;
  localparam logic [SW-1:0] SEL0 = 4'hF;
  localparam logic [SW-1:0] SEL1 = 4'h3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [2:0] m0_cti, m1_cti, s_cti;
  logic [1:0] m0_bte, m1_bte, s_bte;
  logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic s_we, s_cyc, s_stb, s_ack, s_err, s_rty;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stream_arb2 #(.WB_AW(AW), .WB_DW(DW), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  typedef struct {
    logic c0, s0, w0; logic [2:0] t0;
    logic c1, s1, w1; logic [2:0] t1;
    logic ack, err;
    logic e_g, e_cyc, e_stb, e_we; logic [2:0] e_cti;
    logic e_own, e_a0, e_a1, e_e0, e_e1;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic set_m0(input logic c, input logic s, input logic w, input logic [2:0] t);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_cti = t;
  endtask

  task automatic set_m1(input logic c, input logic s, input logic w, input logic [2:0] t);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_cti = t;
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    cyc_start();
    rst = 1'b1;
    set_m0(L, L, L, 3'd0);
    set_m1(L, L, L, 3'd0);
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    cyc_start();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, xfers, n0, n1, prev, errs;
    logic g0, g1, own;

    m0_adr = ADR0; m0_dat_i = DAT0; m0_sel = SEL0; m0_bte = 2'd1;
    m1_adr = ADR1; m1_dat_i = DAT1; m1_sel = SEL1; m1_bte = 2'd2;
    set_m0(H, H, H, 3'd2);
    set_m1(H, H, H, 3'd2);
    s_dat_i = 32'h0; s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;

    // Reset: requests and responses present, yet everything must stay quiet.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("rst_s_stb", {31'b0, s_stb}, 32'd0);
    chk("rst_s_we", {31'b0, s_we}, 32'd0);
    chk("rst_acks", {26'b0, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, 32'd0);
    rst = 1'b0;
    set_m0(L, L, L, 3'd0);
    set_m1(L, L, L, 3'd0);
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    vecs[0]  = '{H,H,L,3'd2, L,L,L,3'd0, L,L, L,L,L,L,3'd0, L,L,L,L,L};
    vecs[1]  = '{H,H,L,3'd2, L,L,L,3'd0, H,L, H,H,H,L,3'd2, L,H,L,L,L};
    vecs[2]  = '{H,H,L,3'd2, L,L,L,3'd0, H,L, H,H,H,L,3'd2, L,H,L,L,L};
    vecs[3]  = '{H,H,L,3'd2, L,L,L,3'd0, H,L, H,H,H,L,3'd2, L,H,L,L,L};
    vecs[4]  = '{H,H,L,3'd7, L,L,L,3'd0, H,L, H,H,H,L,3'd7, L,H,L,L,L};
    vecs[5]  = '{L,L,L,3'd0, L,L,L,3'd0, L,L, H,L,L,L,3'd0, L,L,L,L,L};
    vecs[6]  = '{L,L,L,3'd0, L,L,L,3'd0, H,L, L,L,L,L,3'd0, L,L,L,L,L};
    vecs[7]  = '{H,H,H,3'd0, H,H,H,3'd7, L,L, L,L,L,L,3'd0, L,L,L,L,L};
    vecs[8]  = '{H,H,H,3'd0, H,H,H,3'd7, H,L, H,H,H,H,3'd7, H,L,H,L,L};
    vecs[9]  = '{H,H,H,3'd0, L,L,L,3'd0, L,L, H,L,L,L,3'd0, H,L,L,L,L};
    vecs[10] = '{H,H,H,3'd0, L,L,L,3'd0, H,L, L,L,L,L,3'd0, L,L,L,L,L};
    vecs[11] = '{H,H,H,3'd0, L,L,L,3'd0, L,H, H,H,H,H,3'd0, L,L,L,H,L};
    vecs[12] = '{L,L,L,3'd0, L,L,L,3'd0, L,L, H,L,L,L,3'd0, L,L,L,L,L};
    vecs[13] = '{L,L,L,3'd0, L,L,L,3'd0, L,L, L,L,L,L,3'd0, L,L,L,L,L};

    for (int i = 0; i < 14; i++) begin
      cyc_start();
      set_m0(vecs[i].c0, vecs[i].s0, vecs[i].w0, vecs[i].t0);
      set_m1(vecs[i].c1, vecs[i].s1, vecs[i].w1, vecs[i].t1);
      s_ack = vecs[i].ack; s_err = vecs[i].err;
      s_dat_i = 32'hC0DE_0000 + i;
      @(negedge clk);
      chk($sformatf("v%0d_cyc", i), {31'b0, s_cyc}, {31'b0, vecs[i].e_cyc});
      chk($sformatf("v%0d_stb", i), {31'b0, s_stb}, {31'b0, vecs[i].e_stb});
      chk($sformatf("v%0d_we", i), {31'b0, s_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_cti", i), {29'b0, s_cti}, {29'b0, vecs[i].e_cti});
      chk($sformatf("v%0d_bte", i), {30'b0, s_bte},
          vecs[i].e_g ? (vecs[i].e_own ? 32'd2 : 32'd1) : 32'd0);
      chk($sformatf("v%0d_adr", i), s_adr, vecs[i].e_own ? ADR1 : ADR0);
      chk($sformatf("v%0d_dat", i), s_dat_o, vecs[i].e_own ? DAT1 : DAT0);
      chk($sformatf("v%0d_sel", i), {28'b0, s_sel}, vecs[i].e_own ? {28'b0, SEL1} : {28'b0, SEL0});
      chk($sformatf("v%0d_ack", i), {30'b0, m0_ack, m1_ack}, {30'b0, vecs[i].e_a0, vecs[i].e_a1});
      chk($sformatf("v%0d_err", i), {30'b0, m0_err, m1_err}, {30'b0, vecs[i].e_e0, vecs[i].e_e1});
      chk($sformatf("v%0d_rty", i), {30'b0, m0_rty, m1_rty}, 32'd0);
      chk($sformatf("v%0d_rdat", i), m0_dat_o ^ m1_dat_o ^ m1_dat_o, 32'hC0DE_0000 + i);
      chk($sformatf("v%0d_rdat1", i), m1_dat_o, 32'hC0DE_0000 + i);
    end
    s_err = 1'b0;

    // Mid-burst reset drops s_cyc at once; afterwards a tie goes to m0.
    cyc_start();
    set_m0(H, H, L, 3'd2);
    s_ack = 1'b1;
    cyc_start();
    @(negedge clk);
    chk("mrst_pre_cyc", {31'b0, s_cyc}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_cyc_now", {31'b0, s_cyc}, 32'd0);
    chk("mrst_ack_now", {31'b0, m0_ack}, 32'd0);
    cyc_start();
    rst = 1'b0;
    set_m0(H, H, H, 3'd0);
    set_m1(H, H, H, 3'd0);
    @(negedge clk);
    chk("tie_idle_cyc", {31'b0, s_cyc}, 32'd0);
    cyc_start();
    @(negedge clk);
    chk("tie_first_cyc", {31'b0, s_cyc}, 32'd1);
    chk("tie_first_adr", s_adr, ADR0);
    chk("tie_first_ack", {30'b0, m0_ack, m1_ack}, 32'd2);
    cyc_start();
    set_m0(L, L, L, 3'd0);
    @(negedge clk);
    chk("tie_drop_cyc", {31'b0, s_cyc}, 32'd0);
    cyc_start();
    @(negedge clk);
    chk("tie_gap_cyc", {31'b0, s_cyc}, 32'd0);
    chk("tie_gap_ack", {30'b0, m0_ack, m1_ack}, 32'd0);
    cyc_start();
    @(negedge clk);
    chk("tie_second_cyc", {31'b0, s_cyc}, 32'd1);
    chk("tie_second_adr", s_adr, ADR1);
    chk("tie_second_ack", {30'b0, m0_ack, m1_ack}, 32'd1);
    cyc_start();
    set_m1(L, L, L, 3'd0);
    s_ack = 1'b0;
    cyc_start();

    // Both masters hammer single writes: ownership must alternate.
    g0 = 1'b0; g1 = 1'b0; xfers = 0; n0 = 0; n1 = 0; prev = -1;
    for (int c = 0; c < 80 && xfers < 10; c++) begin
      cyc_start();
      set_m0(!g0, !g0, H, 3'd0);
      set_m1(!g1, !g1, H, 3'd0);
      #1;
      s_ack = s_cyc & s_stb;
      @(negedge clk);
      g0 = m0_ack; g1 = m1_ack;
      if (m0_ack || m1_ack) begin
        own = m1_ack;
        chk("alt_excl", {31'b0, m0_ack & m1_ack}, 32'd0);
        chk("alt_dat", s_dat_o, own ? DAT1 : DAT0);
        if (prev >= 0) chk("alt_order", {31'b0, own}, {31'b0, (prev == 0)});
        prev = own ? 1 : 0;
        xfers++;
        if (own) n1++; else n0++;
      end
    end
    chk("alt_xfers", xfers, 32'd10);
    chk("alt_n0", n0, 32'd5);
    chk("alt_n1", n1, 32'd5);

    // m1 runs an 8-beat burst; m0 asks at beat 2 and must wait.
    rst_pulse();
    beats = 0;
    for (int c = 0; c < 30 && beats < 8; c++) begin
      cyc_start();
      set_m1(H, H, L, (beats == 7) ? 3'd7 : 3'd2);
      set_m0(beats >= 2, beats >= 2, L, 3'd0);
      #1;
      s_ack = s_cyc & s_stb;
      @(negedge clk);
      chk("pre_m0_ack", {31'b0, m0_ack}, 32'd0);
      if (s_cyc) chk("pre_adr", s_adr, ADR1);
      if (m1_ack) beats++;
    end
    chk("pre_beats", beats, 32'd8);
    cyc_start();
    set_m1(L, L, L, 3'd0);
    #1;
    s_ack = s_cyc & s_stb;
    @(negedge clk);
    chk("pre_drop_cyc", {31'b0, s_cyc}, 32'd0);
    cyc_start();
    @(negedge clk);
    chk("pre_gap_cyc", {31'b0, s_cyc}, 32'd0);
    cyc_start();
    #1;
    s_ack = s_cyc & s_stb;
    @(negedge clk);
    chk("pre_m0_cyc", {31'b0, s_cyc}, 32'd1);
    chk("pre_m0_adr", s_adr, ADR0);
    chk("pre_m0_gack", {30'b0, m0_ack, m1_ack}, 32'd2);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers m0: error on the 16th stalled cycle, then abort.
    rst_pulse();
    set_m0(H, H, L, 3'd0);
    @(negedge clk);
    chk("to_idle_cyc", {31'b0, s_cyc}, 32'd0);
    errs = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc_start();
      @(negedge clk);
      chk($sformatf("to_err_%0d", k), {31'b0, m0_err}, (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("to_cyc_%0d", k), {31'b0, s_cyc}, 32'd1);
      if (m0_err) errs++;
    end
    for (int k = 0; k < 2; k++) begin
      cyc_start();
      @(negedge clk);
      chk($sformatf("to_abort_cyc_%0d", k), {31'b0, s_cyc}, 32'd0);
      chk($sformatf("to_abort_rsp_%0d", k), {31'b0, m0_err | m0_ack}, 32'd0);
      if (m0_err) errs++;
    end
    chk("to_err_once", errs, 32'd1);
    cyc_start();
    set_m0(L, L, L, 3'd0);
    cyc_start();
    set_m1(H, H, L, 3'd0);
    @(negedge clk);
    chk("to_back_idle", {31'b0, s_cyc}, 32'd0);
    cyc_start();
    @(negedge clk);
    chk("to_m1_cyc", {31'b0, s_cyc}, 32'd1);
    chk("to_m1_adr", s_adr, ADR1);
    cyc_start();
    set_m1(L, L, L, 3'd0);
`endif

    cyc_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
